// File: rtl/main_pkg.sv
// Shared types and constants for the main-unit scheduler slice.
package main_pkg;

  localparam int W_DEF = 8;

  // Encodings of the unit's 2-bit `on` input.
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_A   = 2'd1;
  localparam logic [1:0] MODE_B   = 2'd2;
  localparam logic [1:0] MODE_C   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/main_scheduler_if.sv
// Requester and unit-side signals of the scheduler; master is the scheduler, slave is its environment.
interface main_scheduler_if import main_pkg::*; #(
  parameter int W = W_DEF
);
  logic [1:0]   req;
  logic [W-1:0] req_x0;
  logic [W-1:0] req_x1;
  logic [1:0]   req_mode0;
  logic [1:0]   req_mode1;
  logic [1:0]   grant;
  logic [1:0]   done;
  logic         err;
  logic [W-1:0] res_y;
  logic [W-1:0] u_x;
  logic [1:0]   u_on;
  logic         u_start;
  logic [W-1:0] u_y;
  logic         u_b;
  logic         u_active;

  modport master (
    input  req, req_x0, req_x1, req_mode0, req_mode1, u_y, u_b, u_active,
    output grant, done, err, res_y, u_x, u_on, u_start
  );

  modport slave (
    output req, req_x0, req_x1, req_mode0, req_mode1, u_y, u_b, u_active,
    input  grant, done, err, res_y, u_x, u_on, u_start
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: ptr names the requester that wins when both ask.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      winner = 2'b01;
      else if (req[1]) winner = 2'b10;
    end else begin
      if (req[1])      winner = 2'b10;
      else if (req[0]) winner = 2'b01;
    end
  end

endmodule

// File: rtl/main_scheduler.sv
// Shares one `main` compute unit between two requesters: arbitrate, load, start, wait, return result.
module main_scheduler import main_pkg::*; #(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input logic             clk,
  input logic             rst,
  main_scheduler_if.master bus
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic [1:0]    grant_q, grant_nx, done_q, done_nx, on_q, on_nx, win;
  logic          err_q, err_nx, start_q, start_nx, ptr, ptr_nx, unit_busy;
  logic [W-1:0]  res_q, res_nx, x_q, x_nx;

  rr_arbiter2 u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (win)
  );

  assign unit_busy   = bus.u_b | bus.u_active;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.res_y   = res_q;
  assign bus.u_x     = x_q;
  assign bus.u_on    = on_q;
  assign bus.u_start = start_q;

  // done/err are registered on the edge that enters FIN, so they are high exactly for the FIN cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant_nx = grant_q;
    done_nx  = 2'b00;
    err_nx   = 1'b0;
    start_nx = start_q;
    x_nx     = x_q;
    on_nx    = on_q;
    res_nx   = res_q;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (win != 2'b00) begin
          x_nx     = win[1] ? bus.req_x1 : bus.req_x0;
          on_nx    = win[1] ? bus.req_mode1 : bus.req_mode0;
          grant_nx = win;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        start_nx = 1'b1;
        cnt_nx   = '0;
        state_nx = START;
      end
      START: begin
        if (unit_busy) begin
          start_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = WAIT;
        end else if (cnt == LAST) begin
          start_nx = 1'b0;
          done_nx  = grant_q;
          err_nx   = 1'b1;
          state_nx = FIN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT: begin
        // A normal finish wins over a timeout that lands on the same cycle.
        if (!unit_busy) begin
          res_nx   = bus.u_y;
          done_nx  = grant_q;
          state_nx = FIN;
        end else if (cnt == LAST) begin
          done_nx  = grant_q;
          err_nx   = 1'b1;
          state_nx = FIN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FIN: begin
        grant_nx = 2'b00;
        ptr_nx   = grant_q[0];
        on_nx    = MODE_OFF;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      x_q     <= '0;
      on_q    <= MODE_OFF;
      res_q   <= '0;
      ptr     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      grant_q <= grant_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
      start_q <= start_nx;
      x_q     <= x_nx;
      on_q    <= on_nx;
      res_q   <= res_nx;
      ptr     <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_main_scheduler.sv
// Bench for main_scheduler: a behavioural unit, a job-timeline reference model and directed scenarios.
module tb_main_scheduler;
  import main_pkg::*;

  localparam int W       = 8;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  main_scheduler_if #(.W(W)) bus ();

  main_scheduler #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural unit: once started it stays busy for `lat` cycles, then presents its result.
  bit           stuck      = 1'b0;
  bit           use_active = 1'b0;
  int           lat        = 6;
  int           ucnt       = 0;
  logic         ubusy      = 1'b0;
  logic [W-1:0] uy         = '0;
  logic [W-1:0] upend      = '0;

  function automatic logic [W-1:0] unitFn(input logic [W-1:0] x, input logic [1:0] m);
    case (m)
      MODE_A:  return x + W'(8);
      MODE_B:  return x << 1;
      MODE_C:  return ~x;
      default: return x;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) begin
        ubusy <= 1'b0;
        uy    <= upend;
      end
    end else if (bus.u_start && !ubusy && !stuck) begin
      ubusy <= 1'b1;
      ucnt  <= lat;
      uy    <= 8'hEE;
      upend <= unitFn(bus.u_x, bus.u_on);
    end
  end

  assign bus.u_b      = (ubusy & ~use_active) | stuck;
  assign bus.u_active = ubusy & use_active;
  assign bus.u_y      = uy;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
  endtask

  // Reference model: each granted job gets a timeline of absolute cycle numbers
  // (grant g, start released ws, done d) worked out from the unit's planned response.
  int           cyc = 0, g = 0, d = 0, ws = 0, ready = 0, owner = 0;
  bit           in_job = 1'b0, errv = 1'b0, ptr = 1'b0, model_on = 1'b0;
  bit           exp_start = 1'b0, exp_err = 1'b0;
  logic [W-1:0] xv = '0, yv = '0, exp_res = '0, exp_x = '0;
  logic [1:0]   exp_on = '0, exp_grant = '0, exp_done = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      model_on = 1'b1;
      in_job   = 1'b0;
      ptr      = 1'b0;
      ready    = cyc + 1;
      exp_res  = '0;
      exp_x    = '0;
      exp_on   = MODE_OFF;
    end else begin
      if (in_job && cyc == d + 1) begin
        in_job = 1'b0;
        ptr    = (owner == 0);
        ready  = cyc + 1;
        exp_on = MODE_OFF;
      end
      if (!in_job && cyc >= ready && bus.req != 2'b00) begin
        owner  = bus.req[ptr] ? int'(ptr) : int'(!ptr);
        xv     = (owner == 1) ? bus.req_x1 : bus.req_x0;
        exp_on = (owner == 1) ? bus.req_mode1 : bus.req_mode0;
        exp_x  = xv;
        yv     = unitFn(xv, exp_on);
        g      = cyc;
        in_job = 1'b1;
        if (stuck) begin
          ws = g + 2; d = ws + TIMEOUT; errv = 1'b1;
        end else begin
          ws = g + 3;
          if (lat <= TIMEOUT) begin d = g + 3 + lat; errv = 1'b0; end
          else begin d = ws + TIMEOUT; errv = 1'b1; end
        end
      end
      if (in_job && cyc == d && !errv) exp_res = yv;
    end
    exp_grant = (in_job && cyc <= d) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    exp_start = in_job && cyc > g && cyc < ws;
    exp_done  = (in_job && cyc == d) ? exp_grant : 2'b00;
    exp_err   = in_job && cyc == d && errv;
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("cyc_grant",   32'(bus.grant),   32'(exp_grant));
      checkOutput("cyc_done",    32'(bus.done),    32'(exp_done));
      checkOutput("cyc_err",     32'(bus.err),     32'(exp_err));
      checkOutput("cyc_res_y",   32'(bus.res_y),   32'(exp_res));
      checkOutput("cyc_u_x",     32'(bus.u_x),     32'(exp_x));
      checkOutput("cyc_u_on",    32'(bus.u_on),    32'(exp_on));
      checkOutput("cyc_u_start", 32'(bus.u_start), 32'(exp_start));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [W-1:0] x0, input logic [W-1:0] x1,
                               input logic [1:0] m0, input logic [1:0] m1);
    bus.req       = r;
    bus.req_x0    = x0;
    bus.req_x1    = x1;
    bus.req_mode0 = m0;
    bus.req_mode1 = m1;
  endtask

  task automatic waitDone(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      tick(1);
      n++;
      if (bus.done != 2'b00) seen = 1'b1;
    end
    if (!seen) checkOutput("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    // Reset held with both requests up.
    rst = 1'b0;
    applyStimulus(2'b11, 8'd0, 8'd0, MODE_OFF, MODE_OFF);
    tick(2);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_done",  32'(bus.done),  32'd0);
    checkOutput("rst_err",   32'(bus.err),   32'd0);
    checkOutput("rst_res_y", 32'(bus.res_y), 32'd0);
    checkOutput("rst_start", 32'(bus.u_start), 32'd0);
    rst = 1'b1;
    applyStimulus(2'b00, 8'd0, 8'd0, MODE_OFF, MODE_OFF);
    tick(3);
    checkOutput("idle_grant", 32'(bus.grant), 32'd0);

    // Single job from requester 0.
    lat = 6;
    applyStimulus(2'b01, 8'd5, 8'd0, MODE_A, MODE_OFF);
    tick(1);
    checkOutput("single_grant", 32'(bus.grant), 32'h1);
    checkOutput("single_u_x",   32'(bus.u_x),   32'd5);
    checkOutput("single_u_on",  32'(bus.u_on),  32'd1);
    tick(1);
    checkOutput("single_start", 32'(bus.u_start), 32'd1);
    waitDone(40, n);
    checkOutput("single_latency", 32'(n), 32'd8);
    checkOutput("single_done",  32'(bus.done),  32'h1);
    checkOutput("single_res_y", 32'(bus.res_y), 32'd13);
    checkOutput("single_err",   32'(bus.err),   32'd0);
    applyStimulus(2'b00, 8'd5, 8'd0, MODE_A, MODE_OFF);
    tick(2);

    // Both requesting: grants alternate starting from requester 0.
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    lat = 3;
    use_active = 1'b1;
    applyStimulus(2'b11, 8'd5, 8'd13, MODE_A, MODE_B);
    waitDone(40, n);
    checkOutput("rr1_done",  32'(bus.done),  32'h1);
    checkOutput("rr1_res_y", 32'(bus.res_y), 32'd13);
    waitDone(40, n);
    checkOutput("rr2_done",  32'(bus.done),  32'h2);
    checkOutput("rr2_res_y", 32'(bus.res_y), 32'd26);
    waitDone(40, n);
    checkOutput("rr3_done",  32'(bus.done),  32'h1);
    checkOutput("rr3_res_y", 32'(bus.res_y), 32'd13);
    applyStimulus(2'b00, 8'd5, 8'd13, MODE_A, MODE_B);
    use_active = 1'b0;
    tick(2);

    // Unit stuck busy: timeout after TIMEOUT wait cycles, result kept.
    stuck = 1'b1;
    applyStimulus(2'b01, 8'd7, 8'd0, MODE_C, MODE_OFF);
    waitDone(100, n);
    checkOutput("to_latency", 32'(n), 32'd67);
    checkOutput("to_done",  32'(bus.done),  32'h1);
    checkOutput("to_err",   32'(bus.err),   32'd1);
    checkOutput("to_res_y", 32'(bus.res_y), 32'd13);
    stuck = 1'b0;
    applyStimulus(2'b00, 8'd7, 8'd0, MODE_C, MODE_OFF);
    tick(2);

    // Reset while requester 1 waits on the unit; pointer returns to requester 0.
    stuck = 1'b1;
    applyStimulus(2'b10, 8'd0, 8'd9, MODE_A, MODE_A);
    tick(10);
    rst = 1'b0;
    tick(1);
    checkOutput("mid_rst_grant", 32'(bus.grant),   32'd0);
    checkOutput("mid_rst_start", 32'(bus.u_start), 32'd0);
    checkOutput("mid_rst_done",  32'(bus.done),    32'd0);
    rst   = 1'b1;
    stuck = 1'b0;
    lat   = 4;
    applyStimulus(2'b11, 8'd3, 8'd9, MODE_A, MODE_A);
    tick(1);
    checkOutput("post_rst_grant", 32'(bus.grant), 32'h1);
    waitDone(40, n);
    checkOutput("post_rst_res_y", 32'(bus.res_y), 32'd11);
    applyStimulus(2'b00, 8'd3, 8'd9, MODE_A, MODE_A);
    tick(2);

    // Requester 0 withdraws mid-job and changes its operand; both re-request before done.
    lat = 8;
    applyStimulus(2'b01, 8'd20, 8'd9, MODE_B, MODE_C);
    tick(5);
    applyStimulus(2'b00, 8'd99, 8'd9, MODE_B, MODE_C);
    tick(2);
    applyStimulus(2'b11, 8'd99, 8'd9, MODE_B, MODE_C);
    waitDone(40, n);
    checkOutput("wd_done",  32'(bus.done),  32'h1);
    checkOutput("wd_res_y", 32'(bus.res_y), 32'd40);
    tick(2);
    checkOutput("wd_next_grant", 32'(bus.grant), 32'h2);
    waitDone(40, n);
    checkOutput("wd_next_res_y", 32'(bus.res_y), 32'hF6);
    applyStimulus(2'b00, 8'd99, 8'd9, MODE_B, MODE_C);
    tick(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
